fsm_seq_serializer: RTL
=======================

Name: fsm_seq_serializer

Overview:
- Parallel-to-serial stage directly upstream of the overlapping Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on dout; dout drives the detector's din.
- Drives a defined idle bit between words, because the detector samples din every cycle.
- Supports gap-free back-to-back words, so overlapping patterns that span word boundaries are still presented contiguously.

Parameters:
WIDTH, 8, word length in bits; legal range 2..64.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
IDLE_BIT, 0, value driven on dout whenever no word is being shifted.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
in_data  in  WIDTH  parallel word to serialize.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  block accepts a word this cycle.
dout  out  1  serial bit stream to the sequence detector din.
dout_vld  out  1  dout carries a word bit (not idle fill).
busy  out  1  a word is currently being shifted out.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; shift register and bit counter clear.
  - Outputs: dout=IDLE_BIT, dout_vld=0, busy=0, in_ready=1.
  - A word in flight is aborted and discarded; it is not resumed.
- States:
  - IDLE: no word loaded.
  - SHIFT: word loaded; cnt counts 0..WIDTH-1 over emitted bits.
- Handshake:
  - Transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_data is ignored when there is no transfer.
  - in_valid may drop at any time without a transfer, with no side effect.
- in_ready = (state==IDLE) or (state==SHIFT and cnt==WIDTH-1).
  - Derived from registered state only; no combinational path from in_valid.
- Transitions:
  - IDLE + transfer -> SHIFT: load in_data, cnt=0.
  - IDLE, no transfer -> stay IDLE.
  - SHIFT, cnt<WIDTH-1 -> shift one position, cnt+1.
  - SHIFT, cnt==WIDTH-1 + transfer -> reload new word, cnt=0, stay SHIFT (back-to-back, zero idle cycles).
  - SHIFT, cnt==WIDTH-1, no transfer -> IDLE.
- Latency:
  - Transfer at edge k -> first word bit on dout during cycle k+1.
  - Last bit on dout during cycle k+WIDTH.
- Outputs in SHIFT:
  - dout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0]; dout_vld=1; busy=1.
- Outputs in IDLE: dout=IDLE_BIT, dout_vld=0, busy=0.
- Shift direction: MSB_FIRST=1 shifts left, MSB_FIRST=0 shifts right; vacated bits fill with IDLE_BIT.
- Counter: cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1. No wrap occurs beyond the reload/IDLE decision.
- dout, dout_vld and busy are functions of registered state only (glitch-free Moore outputs).
- Reset released mid-stream: the first cycle after release is IDLE with in_ready=1, and a transfer is accepted on that edge.

Decomposition:
- Shared package fsm_seq_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the default WIDTH;
  - the detector pattern constant SEQ_1011=4'b1011, used by benches to predict detector output.
- No sub-module: the counter and shift register live inline in fsm_seq_serializer.

Test Plan:
- Reset with in_valid=1 held -> in_ready=1, dout=0, dout_vld=0 while rst=0. After release, the first edge accepts the word.
- Single word 8'hB4, MSB_FIRST=1 -> dout=1,0,1,1,0,1,0,0 in cycles k+1..k+8, dout_vld=1 exactly 8 cycles. Chained detector y=1 in cycle k+5, then dout=0 and dout_vld=0.
- Back-to-back 8'h0B then 8'hB0, in_valid held high -> 16 contiguous dout_vld cycles with no gap. in_ready=1 only on the 8th bit of each word. Detector sees ...1011 1011 across the boundary; y pulses at bits 8 and 12.
- in_valid toggled while busy (cnt=3) -> no transfer, in_ready=0, current word completes unchanged.
- rst asserted at cnt=4 of 8'hFF -> dout drops to 0 and busy to 0 immediately (asynchronously). The word is not resumed after release.
- MSB_FIRST=0, word 8'h0D -> dout=1,0,1,1,0,0,0,0.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_seq_pkg
// Purpose  : Shared definitions for the serializer / sequence-detector slice:
//            state encoding, default word width and the detector pattern.
// Contents : ST_IDLE, ST_SHIFT  - serializer state encoding
//            state_t            - enum built on that encoding
//            DEFAULT_WIDTH      - default serializer word length
//            SEQ_1011           - pattern recognised by the downstream detector
// Revision : 1.0 - initial release
// ============================================================================
package fsm_seq_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   typedef enum logic {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage : fsm_seq_pkg
`default_nettype wire

// File: rtl/fsm_seq_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fsm_seq_serializer
// Purpose  : Parallel-to-serial stage feeding the overlapping Moore sequence
//            detector. Words arrive over valid/ready and leave one bit per
//            clock on dout; a fixed idle bit is driven between words, and
//            back-to-back words are emitted with no gap so patterns spanning
//            a word boundary reach the detector contiguously.
// Ports    : clk      - clock, rising-edge active
//            rst      - asynchronous reset, active low
//            in_data  - parallel word (WIDTH bits)
//            in_valid - in_data valid this cycle
//            in_ready - block accepts a word this cycle
//            dout     - serial bit stream (to detector din)
//            dout_vld - dout carries a word bit, not idle fill
//            busy     - a word is being shifted out
// Revision : 1.0 - initial release
// ============================================================================
module fsm_seq_serializer
   import fsm_seq_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_vld,
   output logic             busy
);

   localparam int                 c_CNT_W    = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_shreg;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_dout;
   logic               r_dout_vld;
   logic               r_busy;
   logic               r_ready;

   logic               w_xfer;

   // Bit that goes on the wire when w is the current shift-register content.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // One shift step towards the output end, back-filling with the idle bit.
   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
      if (MSB_FIRST)
         return {w[WIDTH-2:0], IDLE_BIT};
      else
         return {IDLE_BIT, w[WIDTH-1:1]};
   endfunction

   // r_ready is a registered copy of (IDLE or last bit), so there is no
   // combinational path from in_valid to in_ready.
   assign w_xfer = in_valid & r_ready;

   // Outputs are registered alongside the state: each branch writes the
   // values that belong to the state being entered, so dout/dout_vld/busy
   // change only on clock edges (or asynchronously on reset).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_cnt      <= '0;
         r_dout     <= IDLE_BIT;
         r_dout_vld <= 1'b0;
         r_busy     <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_state    <= S_SHIFT;
                  r_shreg    <= in_data;
                  r_cnt      <= '0;
                  r_dout     <= first_bit(in_data);
                  r_dout_vld <= 1'b1;
                  r_busy     <= 1'b1;
                  r_ready    <= 1'b0;
               end
            end

            S_SHIFT: begin
               if (r_cnt != c_CNT_LAST) begin
                  r_shreg <= shift_once(r_shreg);
                  r_cnt   <= r_cnt + 1'b1;
                  r_dout  <= first_bit(shift_once(r_shreg));
                  // Ready goes high for exactly the last bit of the word.
                  r_ready <= ((r_cnt + 1'b1) == c_CNT_LAST);
               end else if (w_xfer) begin
                  // Back-to-back reload: next word's first bit directly
                  // follows this word's last bit.
                  r_shreg    <= in_data;
                  r_cnt      <= '0;
                  r_dout     <= first_bit(in_data);
                  r_dout_vld <= 1'b1;
                  r_busy     <= 1'b1;
                  r_ready    <= 1'b0;
               end else begin
                  r_state    <= S_IDLE;
                  r_shreg    <= '0;
                  r_cnt      <= '0;
                  r_dout     <= IDLE_BIT;
                  r_dout_vld <= 1'b0;
                  r_busy     <= 1'b0;
                  r_ready    <= 1'b1;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_shreg    <= '0;
               r_cnt      <= '0;
               r_dout     <= IDLE_BIT;
               r_dout_vld <= 1'b0;
               r_busy     <= 1'b0;
               r_ready    <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready = r_ready;
   assign dout     = r_dout;
   assign dout_vld = r_dout_vld;
   assign busy     = r_busy;

endmodule : fsm_seq_serializer
`default_nettype wire
